// File: rtl/busmem.sv
// busmem: Unibus 4K-word memory slave with an ARM register window.
// Define BUSMEM_BACKDOOR_EN to add the ARM memory backdoor on reg 3.
module busmem (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        armwrite,
   input  logic [2:0]  armraddr,
   input  logic [2:0]  armwaddr,
   input  logic [31:0] armwdata,
   output logic [31:0] armrdata,
   input  logic [17:0] a_in_h,
   input  logic [1:0]  c_in_h,
   input  logic [15:0] d_in_h,
   input  logic        msyn_in_h,
   input  logic        init_in_h,
   output logic [15:0] d_out_h,
   output logic        ssyn_out_h
);

   typedef enum logic [1:0] {
      IDLE, DESKEW, ACCESS, HOLD
   } state_t;

   state_t      state, state_n;
   logic [3:0]  dcnt, dcnt_n;
   logic        rdph, rdph_n;
   logic        ssyn_n;
   logic [15:0] dout_n;
   logic        enable;
   logic [4:0]  base;
   logic [15:0] cyclecount;
   logic        cnt_inc;
   logic        bus_wr;
   logic        hit;
   logic [11:0] idx;
   logic        mem_we;
   logic [11:0] mem_wa;
   logic [15:0] mem_wd;
   logic [1:0]  mem_be;
   logic [15:0] mem [4096];

   assign idx = a_in_h[12:1];
   assign hit = enable && (a_in_h[17:13] == base)
                && (base != 5'o37);

`ifdef BUSMEM_BACKDOOR_EN
   logic        bd_req;
   logic        bd_set;
   logic        bdpend;
   logic [11:0] bdindex;
   logic [11:0] pidx;
   logic [15:0] pdata;
   logic        unused_bits;
   assign bd_req = armwrite && (armwaddr == 3'd3)
                   && armwdata[31];
   assign unused_bits = ^armwdata[30:28];
`else
   logic        unused_bits;
   assign unused_bits = ^{armwdata[30:21], armwdata[15:0]};
`endif

   // Bus slave next state; reads present data one clock ahead of SSYN
   always_comb begin
      state_n = state;
      dcnt_n  = dcnt;
      rdph_n  = rdph;
      ssyn_n  = ssyn_out_h;
      dout_n  = d_out_h;
      cnt_inc = 1'b0;
      bus_wr  = 1'b0;
      if (init_in_h) begin
         state_n = IDLE;
         ssyn_n  = 1'b0;
         dout_n  = 16'h0;
         rdph_n  = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (msyn_in_h && hit && !ssyn_out_h) begin
                  state_n = DESKEW;
                  dcnt_n  = 4'd0;
               end
            end
            DESKEW: begin
               if (!msyn_in_h) begin
                  state_n = IDLE;
               end else if (dcnt == 4'd15) begin
                  state_n = ACCESS;
                  rdph_n  = 1'b0;
               end else begin
                  dcnt_n = dcnt + 4'd1;
               end
            end
            ACCESS: begin
               if (c_in_h[1]) begin
                  bus_wr  = 1'b1;
                  ssyn_n  = 1'b1;
                  dout_n  = 16'h0;
                  cnt_inc = 1'b1;
                  state_n = HOLD;
               end else if (!rdph) begin
                  dout_n = mem[idx];
                  rdph_n = 1'b1;
               end else begin
                  ssyn_n  = 1'b1;
                  cnt_inc = 1'b1;
                  rdph_n  = 1'b0;
                  state_n = HOLD;
               end
            end
            HOLD: begin
               if (!msyn_in_h) begin
                  ssyn_n  = 1'b0;
                  dout_n  = 16'h0;
                  state_n = IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Bus slave state and registered bus outputs
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state      <= IDLE;
         dcnt       <= 4'd0;
         rdph       <= 1'b0;
         ssyn_out_h <= 1'b0;
         d_out_h    <= 16'h0;
      end else begin
         state      <= state_n;
         dcnt       <= dcnt_n;
         rdph       <= rdph_n;
         ssyn_out_h <= ssyn_n;
         d_out_h    <= dout_n;
      end
   end

   // ARM-visible control register and SSYN cycle counter
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         enable     <= 1'b0;
         base       <= 5'd0;
         cyclecount <= 16'd0;
      end else begin
         if (armwrite && (armwaddr == 3'd1)) begin
            enable <= armwdata[31];
            base   <= armwdata[20:16];
         end
         if (cnt_inc) begin
            cyclecount <= cyclecount + 16'd1;
         end
      end
   end

   // Single memory write port: bus first, then pending or new backdoor
   always_comb begin
      mem_we = bus_wr;
      mem_wa = idx;
      mem_wd = d_in_h;
      mem_be = c_in_h[0] ? (a_in_h[0] ? 2'b10 : 2'b01) : 2'b11;
`ifdef BUSMEM_BACKDOOR_EN
      bd_set = 1'b0;
      if (bus_wr) begin
         bd_set = bd_req;
      end else if (bdpend) begin
         mem_we = 1'b1;
         mem_wa = pidx;
         mem_wd = pdata;
         mem_be = 2'b11;
         bd_set = bd_req;
      end else if (bd_req) begin
         mem_we = 1'b1;
         mem_wa = armwdata[27:16];
         mem_wd = armwdata[15:0];
         mem_be = 2'b11;
      end
`endif
   end

`ifdef BUSMEM_BACKDOOR_EN
   // Backdoor index and the write deferred behind a bus write
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         bdindex <= 12'd0;
         bdpend  <= 1'b0;
         pidx    <= 12'd0;
         pdata   <= 16'h0;
      end else begin
         if (armwrite && (armwaddr == 3'd3)) begin
            bdindex <= armwdata[27:16];
         end
         bdpend <= bd_set;
         if (bd_set) begin
            pidx  <= armwdata[27:16];
            pdata <= armwdata[15:0];
         end
      end
   end
`endif

   // Memory array with byte lanes; contents are not reset
   always_ff @(posedge CLOCK) begin
      if (mem_we) begin
         if (mem_be[0]) mem[mem_wa][7:0]  <= mem_wd[7:0];
         if (mem_be[1]) mem[mem_wa][15:8] <= mem_wd[15:8];
      end
   end

   // ARM register read mux
   always_comb begin
      armrdata = 32'hDEADBEEF;
      case (armraddr)
         3'd0: armrdata = 32'h424D2003;
         3'd1: armrdata = {enable, 10'b0, base, cyclecount};
`ifdef BUSMEM_BACKDOOR_EN
         3'd3: armrdata = {4'b0, bdindex, mem[bdindex]};
`endif
         default: armrdata = 32'hDEADBEEF;
      endcase
   end

endmodule

// File: tb/tb_busmem.sv
// tb_busmem: random and directed Unibus transfers against a
// transaction-level model of the memory slave.
module tb_busmem;

   logic        CLOCK;
   logic        RESET;
   logic        armwrite;
   logic [2:0]  armraddr;
   logic [2:0]  armwaddr;
   logic [31:0] armwdata;
   logic [31:0] armrdata;
   logic [17:0] a_in_h;
   logic [1:0]  c_in_h;
   logic [15:0] d_in_h;
   logic        msyn_in_h;
   logic        init_in_h;
   logic [15:0] d_out_h;
   logic        ssyn_out_h;

   busmem dut (
      .CLOCK(CLOCK), .RESET(RESET),
      .armwrite(armwrite), .armraddr(armraddr),
      .armwaddr(armwaddr), .armwdata(armwdata),
      .armrdata(armrdata),
      .a_in_h(a_in_h), .c_in_h(c_in_h), .d_in_h(d_in_h),
      .msyn_in_h(msyn_in_h), .init_in_h(init_in_h),
      .d_out_h(d_out_h), .ssyn_out_h(ssyn_out_h)
   );

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;
   logic        exp_ssyn = 1'b0;
   logic [15:0] exp_dout = 16'h0;

   logic [15:0] m_mem [4096];
   logic        m_en = 1'b0;
   logic [4:0]  m_base = 5'd0;
   logic [15:0] m_cnt = 16'd0;

   logic [15:0] rd;
   int          lo;
   logic [31:0] v;

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge CLOCK) begin
      if (chk_en) begin
         chk("ssyn", {31'b0, ssyn_out_h}, {31'b0, exp_ssyn});
         chk("d_out", {16'b0, d_out_h}, {16'b0, exp_dout});
      end
   end

   task automatic arm_wr(input logic [2:0] wa, input logic [31:0] wd);
      @(posedge CLOCK); #1;
      armwrite = 1'b1;
      armwaddr = wa;
      armwdata = wd;
      @(posedge CLOCK); #1;
      armwrite = 1'b0;
      if (wa == 3'd1) begin
         m_en   = wd[31];
         m_base = wd[20:16];
      end
   endtask

   task automatic arm_rd(input logic [2:0] ra, output logic [31:0] val);
      armraddr = ra;
      #1;
      val = armrdata;
   endtask

   // mode: 0 normal, 1 abort in deskew, 2 init in hold,
   // 3 async reset in hold, 4 backdoor write at bus write
   task automatic xfer(input logic [17:0] a, input logic [1:0] c,
                       input logic [15:0] d, input int mode,
                       input logic [15:0] bd,
                       output logic [15:0] rdv, output int lat_obs);
      logic [11:0] ix;
      logic [15:0] w;
      bit mhit;
      bit wr;
      int lat;
      ix = a[12:1];
      mhit = m_en && (a[17:13] == m_base) && (m_base != 5'o37);
      wr = c[1];
      lat = wr ? 17 : 18;
      w = m_mem[ix];
      rdv = 16'h0;
      lat_obs = -1;
      exp_ssyn = 1'b0;
      exp_dout = 16'h0;
      @(posedge CLOCK); #1;
      a_in_h = a;
      c_in_h = c;
      d_in_h = d;
      msyn_in_h = 1'b1;
      if (!mhit || mode == 1) begin
         for (int n = 0; n < 25; n++) begin
            @(posedge CLOCK); #1;
            if (ssyn_out_h && lat_obs < 0) lat_obs = n;
            if (mode == 1 && n == 4) msyn_in_h = 1'b0;
         end
         msyn_in_h = 1'b0;
         @(posedge CLOCK); #1;
         return;
      end
      for (int n = 0; n <= lat; n++) begin
         @(posedge CLOCK); #1;
         if (ssyn_out_h && lat_obs < 0) lat_obs = n;
         if (!wr && n >= 17) exp_dout = w;
         if (mode == 4 && n == 16) begin
            armwrite = 1'b1;
            armwaddr = 3'd3;
            armwdata = {1'b1, 3'b0, ix, bd};
         end
         if (n == lat) begin
            exp_ssyn = 1'b1;
            m_cnt = m_cnt + 16'd1;
            rdv = d_out_h;
            if (wr) begin
               if (c == 2'b11) begin
                  if (a[0]) m_mem[ix][15:8] = d[15:8];
                  else m_mem[ix][7:0] = d[7:0];
               end else begin
                  m_mem[ix] = d;
               end
            end
            if (mode == 4) begin
               armwrite = 1'b0;
               m_mem[ix] = bd;
            end
         end
      end
      if (mode == 2) begin
         init_in_h = 1'b1;
         @(posedge CLOCK); #1;
         exp_ssyn = 1'b0;
         exp_dout = 16'h0;
         chk("init_ssyn", {31'b0, ssyn_out_h}, 32'd0);
         init_in_h = 1'b0;
         msyn_in_h = 1'b0;
         @(posedge CLOCK); #1;
      end else if (mode == 3) begin
         #2;
         chk_en = 1'b0;
         RESET = 1'b0;
         #1;
         chk("rst_ssyn", {31'b0, ssyn_out_h}, 32'd0);
         chk("rst_dout", {16'b0, d_out_h}, 32'd0);
         msyn_in_h = 1'b0;
         exp_ssyn = 1'b0;
         exp_dout = 16'h0;
         m_en = 1'b0;
         m_base = 5'd0;
         m_cnt = 16'd0;
         @(posedge CLOCK); #1;
         RESET = 1'b1;
         chk_en = 1'b1;
      end else begin
         msyn_in_h = 1'b0;
         @(posedge CLOCK); #1;
         exp_ssyn = 1'b0;
         exp_dout = 16'h0;
      end
   endtask

   initial begin
      RESET = 1'b1;
      armwrite = 1'b0;
      armraddr = 3'd0;
      armwaddr = 3'd0;
      armwdata = 32'h0;
      a_in_h = 18'h0;
      c_in_h = 2'b00;
      d_in_h = 16'h0;
      msyn_in_h = 1'b0;
      init_in_h = 1'b0;
      #2 RESET = 1'b0;
      #1;
      chk("rst_ssyn0", {31'b0, ssyn_out_h}, 32'd0);
      chk("rst_dout0", {16'b0, d_out_h}, 32'd0);
      @(posedge CLOCK); #1;
      @(posedge CLOCK); #1;
      RESET = 1'b1;
      chk_en = 1'b1;

      arm_rd(3'd0, v); chk("reg0", v, 32'h424D2003);
      arm_rd(3'd1, v); chk("reg1_rst", v, 32'h0);
      arm_rd(3'd2, v); chk("reg2", v, 32'hDEADBEEF);
      arm_rd(3'd7, v); chk("reg7", v, 32'hDEADBEEF);

      arm_wr(3'd1, {1'b1, 10'b0, 5'd1, 16'h0});
      arm_rd(3'd1, v); chk("reg1_en", v, 32'h80010000);

      xfer(18'o020100, 2'b10, 16'o123456, 0, 16'h0, rd, lo);
      chk("dato_lat", 32'(lo), 32'd17);
      xfer(18'o020100, 2'b00, 16'h0, 0, 16'h0, rd, lo);
      chk("dati_lat", 32'(lo), 32'd18);
      chk("dati_data", {16'b0, rd}, {16'b0, 16'o123456});
      arm_rd(3'd1, v); chk("reg1_cnt2", v, 32'h80010002);

      xfer(18'o020101, 2'b11, 16'o177000, 0, 16'h0, rd, lo);
      xfer(18'o020100, 2'b11, 16'o000377, 0, 16'h0, rd, lo);
      xfer(18'o020100, 2'b01, 16'h0, 0, 16'h0, rd, lo);
      chk("datob_data", {16'b0, rd}, {16'b0, 16'o177377});

      xfer(18'o020100, 2'b10, 16'h0, 1, 16'h0, rd, lo);
      chk("abort_lat", 32'(lo), 32'hFFFFFFFF);
      xfer(18'o020100, 2'b00, 16'h0, 0, 16'h0, rd, lo);
      chk("abort_mem", {16'b0, rd}, {16'b0, 16'o177377});

      for (int i = 0; i < 16; i++) begin
         xfer({5'd1, 12'(i), 1'b0}, 2'b10, 16'($urandom), 0,
              16'h0, rd, lo);
      end
      for (int i = 0; i < 40; i++) begin
         int kind;
         logic [11:0] ix;
         logic [17:0] a;
         kind = int'($urandom_range(0, 9));
         ix = 12'($urandom_range(0, 15));
         a = {5'd1, ix, 1'($urandom_range(0, 1))};
         if (kind == 0) begin
            a[17:13] = 5'($urandom_range(2, 30));
            xfer(a, 2'($urandom_range(0, 3)), 16'($urandom), 0,
                 16'h0, rd, lo);
         end else if (kind == 1) begin
            xfer(a, 2'b10, 16'($urandom), 1, 16'h0, rd, lo);
         end else begin
            xfer(a, 2'($urandom_range(0, 3)), 16'($urandom), 0,
                 16'h0, rd, lo);
         end
      end

      arm_wr(3'd1, {1'b1, 10'b0, 5'o37, 16'h0});
      xfer(18'o777570, 2'b00, 16'h0, 0, 16'h0, rd, lo);
      chk("iopage_lat", 32'(lo), 32'hFFFFFFFF);
      arm_wr(3'd1, {1'b0, 10'b0, 5'd1, 16'h0});
      xfer(18'o020100, 2'b00, 16'h0, 0, 16'h0, rd, lo);
      chk("disabled_lat", 32'(lo), 32'hFFFFFFFF);
      arm_wr(3'd1, {1'b1, 10'b0, 5'd1, 16'h0});
      arm_rd(3'd1, v);
      chk("reg1_model", v, {m_en, 10'b0, m_base, m_cnt});

      xfer(18'o020100, 2'b00, 16'h0, 2, 16'h0, rd, lo);

`ifdef BUSMEM_BACKDOOR_EN
      xfer(18'o020100, 2'b10, 16'o022222, 4, 16'o055555, rd, lo);
      xfer(18'o020100, 2'b00, 16'h0, 0, 16'h0, rd, lo);
      chk("bd_data", {16'b0, rd}, {16'b0, 16'o055555});
      arm_rd(3'd3, v);
      chk("reg3_bd", v, {4'b0, 12'o040, 16'o055555});
`else
      arm_rd(3'd3, v); chk("reg3", v, 32'hDEADBEEF);
      arm_wr(3'd3, {1'b1, 3'b0, 12'o040, 16'o055555});
      xfer(18'o020100, 2'b00, 16'h0, 0, 16'h0, rd, lo);
      chk("nobd_data", {16'b0, rd}, {16'b0, 16'o177377});
`endif

      xfer(18'o020100, 2'b00, 16'h0, 3, 16'h0, rd, lo);
      arm_rd(3'd1, v); chk("reg1_rst2", v, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
